// File: rtl/dbg_ram_pkg.sv
// Shared types for the debug/user RAM arbiter: master identity and the
// registered descriptor of a read whose data returns on the next cycle.
package dbg_ram_pkg;

    typedef enum logic [0:0] {
        M_DBG = 1'b0,
        M_USR = 1'b1
    } master_e;

    typedef struct packed {
        logic    valid;
        master_e owner;
        logic    oor;
    } rd_pend_t;

    // The master that is not m; used to advance the round-robin pointer.
    function automatic master_e other_master(input master_e m);
        return (m == M_DBG) ? M_USR : M_DBG;
    endfunction

endpackage

// File: rtl/dbg_ram_arbiter_if.sv
// Request/grant/address/data bundle for the two RAM masters (UART debug
// and user logic). The arbiter takes the slave side, the masters the other.
interface dbg_ram_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          dbg_wreq;
    logic          dbg_wgnt;
    logic [AW-1:0] dbg_waddr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_rreq;
    logic          dbg_rgnt;
    logic [AW-1:0] dbg_raddr;
    logic [DW-1:0] dbg_rdata;

    logic          usr_wreq;
    logic          usr_wgnt;
    logic [AW-1:0] usr_waddr;
    logic [DW-1:0] usr_wdata;
    logic          usr_rreq;
    logic          usr_rgnt;
    logic [AW-1:0] usr_raddr;
    logic [DW-1:0] usr_rdata;

    modport master (
        output dbg_wreq, dbg_waddr, dbg_wdata, dbg_rreq, dbg_raddr,
        output usr_wreq, usr_waddr, usr_wdata, usr_rreq, usr_raddr,
        input  dbg_wgnt, dbg_rgnt, dbg_rdata,
        input  usr_wgnt, usr_rgnt, usr_rdata
    );

    modport slave (
        input  dbg_wreq, dbg_waddr, dbg_wdata, dbg_rreq, dbg_raddr,
        input  usr_wreq, usr_waddr, usr_wdata, usr_rreq, usr_raddr,
        output dbg_wgnt, dbg_rgnt, dbg_rdata,
        output usr_wgnt, usr_rgnt, usr_rdata
    );

endinterface

// File: rtl/dbg_ram_rr_arb.sv
// Two-master round-robin arbiter. The pointer names the favoured master;
// any grant hands the favour to the other master. Grants are combinational
// from the requests and the pointer; within a master, writes beat reads.
module dbg_ram_rr_arb
    import dbg_ram_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    dbg_wreq,
    input  logic    dbg_rreq,
    input  logic    usr_wreq,
    input  logic    usr_rreq,
    output logic    dbg_wgnt,
    output logic    dbg_rgnt,
    output logic    usr_wgnt,
    output logic    usr_rgnt,
    output logic    gnt_valid,
    output master_e gnt_owner,
    output logic    gnt_write
);

    master_e fav_q;
    master_e fav_d;
    logic    dbg_any;
    logic    usr_any;

    assign dbg_any = dbg_wreq | dbg_rreq;
    assign usr_any = usr_wreq | usr_rreq;

    // Pointer register: favours dbg out of reset.
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge value of its inputs, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fav_q <= M_DBG;
        end else begin
            fav_q <= fav_d;
        end
    end

    // Next pointer: after any grant, favour the master that did not win.
    always_comb begin
        fav_d = fav_q;
        if (gnt_valid) begin
            fav_d = other_master(gnt_owner);
        end
    end

    // Grant decode: the favoured master wins only if it is requesting, so an
    // idle favoured master never blocks the other one. Reset forces no grant.
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        dbg_wgnt  = 1'b0;
        dbg_rgnt  = 1'b0;
        usr_wgnt  = 1'b0;
        usr_rgnt  = 1'b0;
        gnt_valid = 1'b0;
        gnt_owner = M_DBG;
        gnt_write = 1'b0;
        if (rst_n) begin
            if (dbg_any && (fav_q == M_DBG || !usr_any)) begin
                gnt_valid = 1'b1;
                gnt_owner = M_DBG;
                gnt_write = dbg_wreq;
                dbg_wgnt  = dbg_wreq;
                dbg_rgnt  = !dbg_wreq;
            end else if (usr_any) begin
                gnt_valid = 1'b1;
                gnt_owner = M_USR;
                gnt_write = usr_wreq;
                usr_wgnt  = usr_wreq;
                usr_rgnt  = !usr_wreq;
            end
        end
    end

endmodule

// File: rtl/dbg_ram_arbiter.sv
// Shares one single-port synchronous RAM between the UART debug master and
// user logic. One transaction per cycle; read data returns the next cycle
// and is then held per master until that master's next read returns.
// Addresses beyond the RAM depth are granted but never reach the RAM.
module dbg_ram_arbiter
    import dbg_ram_pkg::*;
#(
    parameter int ADDR_BYTE_WIDTH = 4,
    parameter int DATA_BYTE_WIDTH = 4,
    parameter int RAM_AWIDTH      = 10,
    parameter logic [8*DATA_BYTE_WIDTH-1:0] OOR_RDATA =
        (8*DATA_BYTE_WIDTH)'(32'hDEADBEEF)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    dbg_ram_arbiter_if.slave                     bus,
    output logic                                 ram_en,
    output logic                                 ram_we,
    output logic [RAM_AWIDTH-1:0]                ram_addr,
    output logic [8*DATA_BYTE_WIDTH-1:0]         ram_wdata,
    input  logic [8*DATA_BYTE_WIDTH-1:0]         ram_rdata
);

    localparam int AW = 8 * ADDR_BYTE_WIDTH;
    localparam int DW = 8 * DATA_BYTE_WIDTH;

    logic          gnt_valid;
    master_e       gnt_owner;
    logic          gnt_write;

    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          g_oor;

    rd_pend_t      pend_q;
    logic [DW-1:0] rd_ret;
    logic [DW-1:0] hold_dbg_q;
    logic [DW-1:0] hold_usr_q;

    dbg_ram_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .dbg_wreq  (bus.dbg_wreq),
        .dbg_rreq  (bus.dbg_rreq),
        .usr_wreq  (bus.usr_wreq),
        .usr_rreq  (bus.usr_rreq),
        .dbg_wgnt  (bus.dbg_wgnt),
        .dbg_rgnt  (bus.dbg_rgnt),
        .usr_wgnt  (bus.usr_wgnt),
        .usr_rgnt  (bus.usr_rgnt),
        .gnt_valid (gnt_valid),
        .gnt_owner (gnt_owner),
        .gnt_write (gnt_write)
    );

    // Select the address and write data of the granted request.
    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        if (gnt_owner == M_DBG) begin
            g_addr  = gnt_write ? bus.dbg_waddr : bus.dbg_raddr;
            g_wdata = bus.dbg_wdata;
        end else begin
            g_addr  = gnt_write ? bus.usr_waddr : bus.usr_raddr;
            g_wdata = bus.usr_wdata;
        end
    end

    // Any address bit at or above the RAM depth marks the access out of range.
    assign g_oor = (g_addr >> RAM_AWIDTH) != '0;

    // RAM port: driven only in a granted cycle; out-of-range never enables it.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt_valid) begin
            ram_en    = !g_oor;
            ram_we    = !g_oor && gnt_write;
            ram_addr  = g_addr[RAM_AWIDTH-1:0];
            ram_wdata = gnt_write ? g_wdata : '0;
        end
    end

    // Pending-read descriptor, captured at the grant edge of a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q.valid <= gnt_valid && !gnt_write;
            pend_q.owner <= gnt_owner;
            pend_q.oor   <= g_oor;
        end
    end

    // Data returned this cycle for the pending read.
    assign rd_ret = pend_q.oor ? OOR_RDATA : ram_rdata;

    // Hold registers capture the returning data at the end of the return cycle.
    // NOTE: these are ordinary flops rather than a memory array, so they take
    // the async reset; the RAM contents themselves are never reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_dbg_q <= '0;
            hold_usr_q <= '0;
        end else if (pend_q.valid) begin
            if (pend_q.owner == M_DBG) begin
                hold_dbg_q <= rd_ret;
            end else begin
                hold_usr_q <= rd_ret;
            end
        end
    end

    // Read data: live RAM data during the owner's return cycle, else held value.
    always_comb begin
        bus.dbg_rdata = hold_dbg_q;
        bus.usr_rdata = hold_usr_q;
        if (pend_q.valid) begin
            if (pend_q.owner == M_DBG) begin
                bus.dbg_rdata = rd_ret;
            end else begin
                bus.usr_rdata = rd_ret;
            end
        end
    end

endmodule

// File: tb/tb_dbg_ram_arbiter.sv
// Self-checking bench for dbg_ram_arbiter: directed vector table, a reset
// mid-read sequence, then randomized traffic against a behavioural model.
module tb_dbg_ram_arbiter;
    import dbg_ram_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int RAW = 10;
    localparam logic [31:0] OOR = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dbg_ram_arbiter_if #(.AW(AW), .DW(DW)) bus();

    logic           ram_en;
    logic           ram_we;
    logic [RAW-1:0] ram_addr;
    logic [DW-1:0]  ram_wdata;
    logic [DW-1:0]  ram_rdata;

    dbg_ram_arbiter #(
        .ADDR_BYTE_WIDTH (4),
        .DATA_BYTE_WIDTH (4),
        .RAM_AWIDTH      (RAW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Single-port synchronous RAM with one-cycle read latency.
    logic [DW-1:0] tb_mem [0:(1<<RAW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) tb_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= tb_mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic        m_fav_usr;       // 1: the user master is favoured next
    logic        m_pv;            // a read's data returns this cycle
    logic        m_pown;          // 0 dbg, 1 usr
    logic [31:0] m_pdata;
    logic [31:0] m_hold [2];
    logic [31:0] m_mem [int];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return m_mem.exists(int'(a)) ? m_mem[int'(a)] : 32'h0;
    endfunction

    task automatic model_reset();
        m_fav_usr = 1'b0;
        m_pv      = 1'b0;
        m_pown    = 1'b0;
        m_pdata   = '0;
        m_hold[0] = '0;
        m_hold[1] = '0;
    endtask

    typedef struct packed {
        logic        rst_before;
        logic        dw, dr, uw, ur;
        logic [31:0] dwa, dwd, dra, uwa, uwd, ura;
        logic [3:0]  gnt;        // {dbg_w, dbg_r, usr_w, usr_r}
        logic        en, we;
        logic [31:0] addr, wdata, drd, urd;
    } vec_t;

    task automatic drive(input vec_t v);
        bus.dbg_wreq  = v.dw;  bus.dbg_rreq  = v.dr;
        bus.usr_wreq  = v.uw;  bus.usr_rreq  = v.ur;
        bus.dbg_waddr = v.dwa; bus.dbg_wdata = v.dwd; bus.dbg_raddr = v.dra;
        bus.usr_waddr = v.uwa; bus.usr_wdata = v.uwd; bus.usr_raddr = v.ura;
    endtask

    task automatic do_reset();
        vec_t idle;
        idle = '0;
        @(negedge clk);
        rst_n = 1'b0;
        drive(idle);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One bus cycle: drive at negedge, compare mid-cycle, advance model at posedge.
    task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
        int          sel;
        logic        wr, oor, e_en, e_we;
        logic [31:0] a, d, e_drd, e_urd;
        logic [3:0]  e_gnt, a_gnt;
        @(negedge clk);
        drive(v);
        #1;
        if (!m_fav_usr) sel = (v.dw | v.dr) ? 0 : ((v.uw | v.ur) ? 1 : -1);
        else            sel = (v.uw | v.ur) ? 1 : ((v.dw | v.dr) ? 0 : -1);
        wr = (sel == 0) ? v.dw : (sel == 1) ? v.uw : 1'b0;
        a  = (sel == 0) ? (wr ? v.dwa : v.dra) : (wr ? v.uwa : v.ura);
        d  = (sel == 0) ? v.dwd : v.uwd;
        oor = a >= 32'(1 << RAW);
        e_gnt = {sel == 0 && wr, sel == 0 && !wr, sel == 1 && wr, sel == 1 && !wr};
        e_en  = (sel >= 0) && !oor;
        e_we  = e_en && wr;
        e_drd = (m_pv && m_pown == 1'b0) ? m_pdata : m_hold[0];
        e_urd = (m_pv && m_pown == 1'b1) ? m_pdata : m_hold[1];
        a_gnt = {bus.dbg_wgnt, bus.dbg_rgnt, bus.usr_wgnt, bus.usr_rgnt};

        check({tag, " gnt"}, 32'(a_gnt), 32'(e_gnt));
        check({tag, " ram_en"}, 32'(ram_en), 32'(e_en));
        check({tag, " ram_we"}, 32'(ram_we), 32'(e_we));
        if (e_en) check({tag, " ram_addr"}, 32'(ram_addr), a);
        if (e_we) check({tag, " ram_wdata"}, ram_wdata, d);
        check({tag, " dbg_rdata"}, bus.dbg_rdata, e_drd);
        check({tag, " usr_rdata"}, bus.usr_rdata, e_urd);
        if (use_tbl) begin
            check({tag, " tbl gnt"}, 32'(a_gnt), 32'(v.gnt));
            check({tag, " tbl ram_en"}, 32'(ram_en), 32'(v.en));
            check({tag, " tbl ram_we"}, 32'(ram_we), 32'(v.we));
            if (v.en) check({tag, " tbl ram_addr"}, 32'(ram_addr), v.addr);
            if (v.we) check({tag, " tbl ram_wdata"}, ram_wdata, v.wdata);
            check({tag, " tbl dbg_rdata"}, bus.dbg_rdata, v.drd);
            check({tag, " tbl usr_rdata"}, bus.usr_rdata, v.urd);
        end

        @(posedge clk);
        if (m_pv) m_hold[m_pown] = m_pdata;
        m_pv = 1'b0;
        if (sel >= 0) begin
            m_fav_usr = (sel == 0);
            if (wr) begin
                if (!oor) m_mem[int'(a)] = d;
            end else begin
                m_pv    = 1'b1;
                m_pown  = (sel == 1);
                m_pdata = oor ? OOR : mem_rd(a);
            end
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(RAW, 31));
        return a;
    endfunction

    vec_t tbl [18];
    vec_t v;

    initial begin
        //            rst dw dr uw ur  dwa      dwd           dra      uwa      uwd           ura      gnt      en  we  addr     wdata         drd           urd
        tbl[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h010, 32'h12345678, 32'h0,   32'h0,   32'h0,        32'h0,   4'b1000, 1'b1,1'b1, 32'h010, 32'h12345678, 32'h0,        32'h0};
        tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h0,        32'h010, 32'h0,   32'h0,        32'h0,   4'b0100, 1'b1,1'b0, 32'h010, 32'h0,        32'h0,        32'h0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,        32'h0,   32'h0,   32'h0,        32'h0,   4'b0000, 1'b0,1'b0, 32'h0,   32'h0,        32'h12345678, 32'h0};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,        32'h0,   32'h0,   32'h0,        32'h0,   4'b0000, 1'b0,1'b0, 32'h0,   32'h0,        32'h12345678, 32'h0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 32'h0,   32'h0,        32'h0,   32'h020, 32'hA5A50001, 32'h020, 4'b0010, 1'b1,1'b1, 32'h020, 32'hA5A50001, 32'h12345678, 32'h0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,   32'h0,        32'h0,   32'h0,   32'h0,        32'h020, 4'b0001, 1'b1,1'b0, 32'h020, 32'h0,        32'h12345678, 32'h0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,        32'h0,   32'h0,   32'h0,        32'h0,   4'b0000, 1'b0,1'b0, 32'h0,   32'h0,        32'h12345678, 32'hA5A50001};
        tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h0,        32'h400, 32'h0,   32'h0,        32'h0,   4'b0100, 1'b0,1'b0, 32'h0,   32'h0,        32'h12345678, 32'hA5A50001};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h400, 32'hFFFF0000, 32'h0,   32'h0,   32'h0,        32'h0,   4'b1000, 1'b0,1'b0, 32'h0,   32'h0,        OOR,          32'hA5A50001};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,   32'h0,        32'h000, 32'h0,   32'h0,        32'h0,   4'b0100, 1'b1,1'b0, 32'h000, 32'h0,        OOR,          32'hA5A50001};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,        32'h0,   32'h0,   32'h0,        32'h0,   4'b0000, 1'b0,1'b0, 32'h0,   32'h0,        32'h0,        32'hA5A50001};
        tbl[11] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 32'h0,   32'h0,        32'h010, 32'h0,   32'h0,        32'h020, 4'b0001, 1'b1,1'b0, 32'h020, 32'h0,        32'h0,        32'hA5A50001};
        tbl[12] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 32'h0,   32'h0,        32'h010, 32'h0,   32'h0,        32'h020, 4'b0100, 1'b1,1'b0, 32'h010, 32'h0,        32'h0,        32'hA5A50001};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,        32'h0,   32'h0,   32'h0,        32'h0,   4'b0000, 1'b0,1'b0, 32'h0,   32'h0,        32'h12345678, 32'hA5A50001};
        tbl[14] = '{1'b1,1'b0,1'b1,1'b0,1'b1, 32'h0,   32'h0,        32'h010, 32'h0,   32'h0,        32'h020, 4'b0100, 1'b1,1'b0, 32'h010, 32'h0,        32'h0,        32'h0};
        tbl[15] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 32'h0,   32'h0,        32'h010, 32'h0,   32'h0,        32'h020, 4'b0001, 1'b1,1'b0, 32'h020, 32'h0,        32'h12345678, 32'h0};
        tbl[16] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 32'h0,   32'h0,        32'h010, 32'h0,   32'h0,        32'h020, 4'b0100, 1'b1,1'b0, 32'h010, 32'h0,        32'h12345678, 32'hA5A50001};
        tbl[17] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 32'h0,   32'h0,        32'h010, 32'h0,   32'h0,        32'h020, 4'b0001, 1'b1,1'b0, 32'h020, 32'h0,        32'h12345678, 32'hA5A50001};

        for (int i = 0; i < (1 << RAW); i++) tb_mem[i] = '0;
        v = '0;
        drive(v);
        model_reset();

        // Outputs while reset is held.
        #2;
        check("rst gnt", 32'({bus.dbg_wgnt, bus.dbg_rgnt, bus.usr_wgnt, bus.usr_rgnt}), 32'h0);
        check("rst ram_en", 32'(ram_en), 32'h0);
        check("rst dbg_rdata", bus.dbg_rdata, 32'h0);
        check("rst usr_rdata", bus.usr_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst_before) do_reset();
            run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Reset asserted the cycle after a dbg read grant.
        v = '0; v.dr = 1'b1; v.dra = 32'h010;
        run_cycle(v, 1'b0, "pre-rst read");
        @(negedge clk);
        rst_n = 1'b0;
        v.ur = 1'b1; v.ura = 32'h020; v.dw = 1'b1; v.dwa = 32'h3; v.dwd = 32'h55;
        drive(v);
        model_reset();
        #1;
        check("midrst gnt", 32'({bus.dbg_wgnt, bus.dbg_rgnt, bus.usr_wgnt, bus.usr_rgnt}), 32'h0);
        check("midrst ram_en", 32'(ram_en), 32'h0);
        check("midrst ram_we", 32'(ram_we), 32'h0);
        check("midrst ram_addr", 32'(ram_addr), 32'h0);
        check("midrst ram_wdata", ram_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '0;
        drive(v);
        #1;
        check("postrst dbg_rdata", bus.dbg_rdata, 32'h0);
        check("postrst usr_rdata", bus.usr_rdata, 32'h0);
        v.dr = 1'b1; v.dra = 32'h010; v.ur = 1'b1; v.ura = 32'h020;
        v.gnt = 4'b0100; v.en = 1'b1; v.addr = 32'h010; v.drd = 32'h0; v.urd = 32'h0;
        run_cycle(v, 1'b1, "postrst favour");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v = '0;
            v.dw  = ($urandom_range(0, 3) == 0);
            v.dr  = ($urandom_range(0, 2) == 0);
            v.uw  = ($urandom_range(0, 3) == 0);
            v.ur  = ($urandom_range(0, 2) == 0);
            v.dwa = rnd_addr(); v.dra = rnd_addr();
            v.uwa = rnd_addr(); v.ura = rnd_addr();
            v.dwd = $urandom;   v.uwd = $urandom;
            run_cycle(v, 1'b0, $sformatf("rnd%0d", i));
        end
        v = '0;
        run_cycle(v, 1'b0, "drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
